// File: rtl/mux_select_scanner.sv
// mux_select_scanner
//
// Walks the select of a downstream 8:1 (generally 2**SEL_W:1) multiplexer
// through every channel, waits SETTLE_CYC cycles for the mux output to
// settle, samples it for one cycle, and packs the samples into a result
// word. A one-cycle done pulse marks the moment the new result appears.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   request a full scan (ignored while busy)
//   y_in       in   output of the downstream mux
//   sel        out  SEL_W-bit mux select
//   busy       out  high while a scan is in progress
//   done       out  one-cycle pulse, result updated in the same cycle
//   result     out  N bits, bit i = y_in sampled while sel == i
//   dbg_state  out  current FSM state (IDLE=0, SETTLE=1, SAMPLE=2)
//
// Handshake: start is a level sampled on each rising edge. It is accepted
// only in IDLE (including the done cycle, which allows back-to-back scans)
// and is dropped silently otherwise; there is no queueing.
module mux_select_scanner #(
    parameter int SEL_W      = 3,
    parameter int SETTLE_CYC = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  y_in,
    output logic [SEL_W-1:0]      sel,
    output logic                  busy,
    output logic                  done,
    output logic [(2**SEL_W)-1:0] result,
    output logic [1:0]            dbg_state
);

    localparam int N = 2 ** SEL_W;

    // Settle counter is 4 bits wide: SETTLE_CYC is limited to 1..15.
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [N-1:0]   scratch_q, scratch_d;
    logic [N-1:0]   result_q, result_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            scratch_q <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // sel keeps its last value while idle; a new scan always
                // restarts at channel 0.
                if (start) begin
                    sel_d     = '0;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SETTLE;
                end
            end

            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            SAMPLE: begin
                scratch_d[sel_q] = y_in;
                if (sel_q == SEL_LAST) begin
                    // The last bit bypasses scratch so result and done
                    // land on the same edge.
                    result_d        = scratch_q;
                    result_d[N-1]   = y_in;
                    done_d          = 1'b1;
                    busy_d          = 1'b0;
                    state_d         = IDLE;
                end else begin
                    sel_d   = sel_q + 1'b1;
                    state_d = SETTLE;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign sel       = sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: doc/mux_select_scanner.md
Name: mux_select_scanner

Overview:
Sequential select driver that sits directly upstream of the mux8 8:1 multiplexer. It steps the mux select through every channel and samples the mux output after a settle delay. It packs the N sampled bits into a result word and pulses done when the scan completes. This replaces hand-stepped select stimulus with a clocked, handshaked scan of all mux inputs.

Parameters:
SEL_W, 3, select width; channel count N = 2**SEL_W (8 for mux8).
SETTLE_CYC, 1, cycles sel is held stable before sampling y_in; legal range 1..15.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request a full scan; sampled on rising edge of clk.
y_in  input  1  output of the downstream mux (y8 of mux8).
sel  output  SEL_W  drives mux select (s8 of mux8).
busy  output  1  high while a scan is in progress.
done  output  1  one-cycle pulse: scan finished, result updated.
result  output  N  bit i = y_in sampled while sel == i.

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous and active-high; all state and outputs change only on rising edge of clk.
- Reset: state=IDLE, sel=0, busy=0, done=0, result=0, scratch=0, settle count=0. Reset mid-scan aborts the scan; partial data is discarded; result is forced to 0.
- States: IDLE, SETTLE, SAMPLE.
- IDLE: done=0 unless this is the cycle right after the last SAMPLE.
  - start=1 -> sel=0, scratch=0, cnt=0, busy=1, go SETTLE.
  - start=0 -> stay in IDLE; sel holds its last value.
- SETTLE: sel held constant; cnt increments each cycle.
  - When cnt == SETTLE_CYC-1 -> go SAMPLE, cnt=0.
- SAMPLE (1 cycle): scratch[sel] <= y_in.
  - If sel != N-1 -> sel <= sel+1, go SETTLE.
  - If sel == N-1 -> result <= scratch with bit N-1 = y_in, done <= 1, busy <= 0, go IDLE. sel stays at N-1.
- done is high for exactly one cycle and coincides with the first cycle the new result is visible. busy and done are never both high.
- Timing:
  - Each channel takes SETTLE_CYC+1 cycles.
  - Start sampled at edge k -> busy high from edge k+1; done high at edge k+1+N*(SETTLE_CYC+1). Default: done at k+17.
- start while busy: ignored; no restart, no queueing.
- start in the done cycle (state IDLE): accepted. This gives back-to-back scans with zero idle gap; done and the new busy are on adjacent cycles.
- result is held between scans and changes only at a done pulse or at reset.
- sel increments by 1 per channel, no wrap inside a scan. A new scan always restarts at 0.
- y_in is only sampled in SAMPLE; values in other states have no effect.

Test Plan:
- Reset then idle: assert reset 2 cycles, start=0 for 10 cycles -> sel=0, busy=0, done=0, result=8'h00 throughout.
- Single scan, mux8 data d7..d0=8'b1010_0110: pulse start at edge 0 -> sel visits 0..7, each held 2 cycles; done at edge 17 only; result=8'hA6; busy high edges 1..16.
- One-hot walk: repeat the scan with only dI=1 for I=0..7 -> result = 8'h01, 8'h02, ..., 8'h80. The y_in sampling window is the SAMPLE cycle only.
- Start while busy: pulse start at edge 0 and edge 5 -> exactly one done at edge 17, sel sequence unchanged.
- Back-to-back: start=1 held continuously, data 8'hFF then 8'h3C -> done at edges 17 and 34, results 8'hFF then 8'h3C, busy low only in the done cycles.
- Reset mid-scan: assert reset at edge 9 of a scan with data 8'hFF -> the next cycle has sel=0, busy=0, result=8'h00, and no done pulse appears.
